// File: rtl/sha512_compress.sv
// Iterative SHA-512/384 compression core: one 1024-bit block per transaction, one round per
// clock over a rolling 16-word schedule window, result accumulated into the chaining state.
module sha512_compress #(
  parameter bit SHA384 = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_first,
  input  logic [1023:0] in_block,
  output logic          digest_valid,
  output logic [511:0]  digest,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  localparam logic [511:0] IV512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam logic [511:0] IV384 = {
    64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
  localparam logic [511:0] IV = SHA384 ? IV384 : IV512;

  localparam logic [63:0] K [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

  function automatic logic [63:0] bsig0(input logic [63:0] x);
    return {x[27:0], x[63:28]} ^ {x[33:0], x[63:34]} ^ {x[38:0], x[63:39]};
  endfunction

  function automatic logic [63:0] bsig1(input logic [63:0] x);
    return {x[13:0], x[63:14]} ^ {x[17:0], x[63:18]} ^ {x[40:0], x[63:41]};
  endfunction

  function automatic logic [63:0] ssig0(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  function automatic logic [63:0] ssig1(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  state_t      state;
  logic [6:0]  t;
  logic [511:0] hv;
  logic [63:0] w [16];
  logic [63:0] a, b, c, d, e, f, g, h;
  logic [63:0] t1, t2, w_next;
  logic [511:0] h_sum;

  assign busy = ~in_ready;

  assign t1     = h + bsig1(e) + ((e & f) ^ (~e & g)) + K[t] + w[0];
  assign t2     = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
  // Word t+16 of the schedule, entering the window as word t leaves it.
  assign w_next = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
  assign h_sum  = {hv[511:448] + a, hv[447:384] + b, hv[383:320] + c, hv[319:256] + d,
                   hv[255:192] + e, hv[191:128] + f, hv[127:64]  + g, hv[63:0]    + h};

  // NOTE: the window and working variables carry no reset; every transaction reloads them
  // on the accept edge before they are read, so resetting them would only add fan-out.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      for (int i = 0; i < 16; i++) w[i] <= in_block[1023 - 64*i -: 64];
      {a, b, c, d, e, f, g, h} <= in_first ? IV : hv;
    end else if (state == ROUND) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_next;
      h <= g;
      g <= f;
      f <= e;
      e <= d + t1;
      d <= c;
      c <= b;
      b <= a;
      a <= t1 + t2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      t            <= 7'd0;
      in_ready     <= 1'b1;
      digest_valid <= 1'b0;
      digest       <= '0;
      hv           <= IV;
    end else begin
      digest_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            // A new message chains from the IV rather than the previous result.
            if (in_first) hv <= IV;
            t        <= 7'd0;
            in_ready <= 1'b0;
            state    <= ROUND;
          end
        end
        ROUND: begin
          if (t == 7'd79) begin
            t     <= 7'd0;
            state <= FINAL;
          end else begin
            t <= t + 7'd1;
          end
        end
        FINAL: begin
          hv           <= h_sum;
          digest       <= h_sum;
          digest_valid <= 1'b1;
          in_ready     <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
